// File: rtl/bcd_pkg.sv
// Shared types and constants for the BCD stopwatch controller.
package bcd_pkg;
  localparam int DIG_W = 4;
  localparam logic [DIG_W-1:0] BCD_MAX = 4'd9;

  typedef enum logic [1:0] {IDLE, RUN, PAUSE, LAP} state_t;
endpackage

// File: rtl/bcd_stopwatch_ctrl_if.sv
// Button pulses in, display bus and status flags out.
interface bcd_stopwatch_ctrl_if #(parameter int NDIG = 4);
  logic                start_stop;
  logic                clear;
  logic                lap;
  logic [4*NDIG-1:0]   dout;
  logic                running;
  logic                lap_active;
  logic                tick;
  logic                overflow;

  modport master (output start_stop, clear, lap,
                  input  dout, running, lap_active, tick, overflow);
  modport slave  (input  start_stop, clear, lap,
                  output dout, running, lap_active, tick, overflow);
endinterface

// File: rtl/bcd_digit.sv
// One BCD decade; values above 9 are treated as 9 so a corrupted digit self-heals.
module bcd_digit
  import bcd_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc_en,
  output logic [DIG_W-1:0] digit,
  output logic [DIG_W-1:0] digit_nxt,
  output logic             carry_out
);
  always_comb begin
    carry_out = inc_en && (digit >= BCD_MAX);
    digit_nxt = digit;
    if (clr)         digit_nxt = '0;
    else if (inc_en) digit_nxt = carry_out ? '0 : digit + DIG_W'(1);
  end

  always_ff @(posedge clk or posedge rst)
    if (rst) digit <= '0;
    else     digit <= digit_nxt;
endmodule

// File: rtl/bcd_stopwatch_ctrl.sv
// Start/stop/lap stopwatch: prescaler, run FSM and a cascaded BCD digit chain.
module bcd_stopwatch_ctrl
  import bcd_pkg::*;
#(
  parameter int DIVISOR = 100000000,
  parameter int NDIG    = 4
) (
  input  logic                  CLK,
  input  logic                  reset,
  bcd_stopwatch_ctrl_if.slave   bus
);
  localparam int PW = (DIVISOR > 2) ? $clog2(DIVISOR) : 1;

  state_t                       state, nxt;
  logic [PW-1:0]                presc;
  logic                         counting, tick;
  logic                         running_q, lap_q, ovf_q;
  logic [NDIG:0]                carry;
  logic [NDIG-1:0][DIG_W-1:0]   live, live_nxt, snap;

  assign counting = (state == RUN) || (state == LAP);
  assign tick     = counting && (presc == PW'(DIVISOR - 1));
  assign carry[0] = tick;

  always_comb begin
    nxt = state;
    if (bus.clear) nxt = IDLE;
    else begin
      case (state)
        IDLE:    if (bus.start_stop) nxt = RUN;
        RUN:     if (bus.start_stop) nxt = PAUSE; else if (bus.lap) nxt = LAP;
        LAP:     if (bus.start_stop) nxt = PAUSE; else if (bus.lap) nxt = RUN;
        PAUSE:   if (bus.start_stop) nxt = RUN;
        default: nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK or posedge reset)
    if (reset) begin
      state     <= IDLE;
      running_q <= 1'b0;
      lap_q     <= 1'b0;
    end else begin
      state     <= nxt;
      running_q <= (nxt == RUN) || (nxt == LAP);
      lap_q     <= (nxt == LAP);
    end

  // Prescaler holds in PAUSE so a resume finishes the partial period.
  always_ff @(posedge CLK or posedge reset)
    if (reset)          presc <= '0;
    else if (bus.clear) presc <= '0;
    else if (counting)  presc <= tick ? '0 : presc + PW'(1);

  for (genvar i = 0; i < NDIG; i++) begin : g_dig
    bcd_digit u_dig (
      .clk       (CLK),
      .rst       (reset),
      .clr       (bus.clear),
      .inc_en    (carry[i]),
      .digit     (live[i]),
      .digit_nxt (live_nxt[i]),
      .carry_out (carry[i+1])
    );
  end

  // Snapshot takes the post-edge digits so a lap on a tick edge shows the new value.
  always_ff @(posedge CLK or posedge reset)
    if (reset) begin
      snap  <= '0;
      ovf_q <= 1'b0;
    end else if (bus.clear) begin
      snap  <= '0;
      ovf_q <= 1'b0;
    end else begin
      if (state == RUN && nxt == LAP) snap <= live_nxt;
      if (carry[NDIG])                ovf_q <= 1'b1;
    end

  assign bus.dout       = (state == LAP) ? snap : live;
  assign bus.running    = running_q;
  assign bus.lap_active = lap_q;
  assign bus.tick       = tick;
  assign bus.overflow   = ovf_q;
endmodule
